// File: rtl/mult_pkg.sv
// Shared types and constants for the multi-cycle multiply sequencer.
package mult_pkg;

    localparam int MULT_W     = 32;
    localparam int MULT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator and signed result fix-up.
// With MULT_EARLY_EXIT_EN defined it also reports when the remaining multiplier is exhausted.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             finish,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
`ifdef MULT_EARLY_EXIT_EN
    output logic             mplier_next_zero,
`endif
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    logic [2*WIDTH-1:0] acc_q, acc_d, acc_next;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d, mplier_next;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_q, neg_d;

    always_comb begin
        // Magnitudes are only taken for signed ops; 0x80000000 stays 0x80000000 read as unsigned.
        mag_a       = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
        mag_b       = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
        acc_next    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_next = mplier_q >> 1;

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        prod_d   = prod_q;

        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mag_a};
            mplier_d = mag_b;
            neg_d    = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (step) begin
            acc_d    = acc_next;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_next;
            if (finish) begin
                prod_d = neg_q ? -acc_next : acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
        end
    end

`ifdef MULT_EARLY_EXIT_EN
    assign mplier_next_zero = (mplier_next == '0);
`endif
    assign product_lo = prod_q[WIDTH-1:0];
    assign product_hi = prod_q[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mult_seq.sv
// Multiply sequencer: IDLE/CALC/DONE control, iteration counter and pipeline freeze.
// Define MULT_EARLY_EXIT_EN to leave CALC as soon as the multiplier runs out of set bits.
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             freeze,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi
);

    localparam logic [MULT_CNT_W-1:0] LAST_CNT = MULT_CNT_W'(WIDTH - 1);

    mult_state_e             state_q, state_d;
    logic [MULT_CNT_W-1:0]   count_q, count_d;
    logic                    load, step, finish, last_iter;
`ifdef MULT_EARLY_EXIT_EN
    logic                    mplier_next_zero;

    assign last_iter = (count_q == LAST_CNT) || mplier_next_zero;
`else
    assign last_iter = (count_q == LAST_CNT);
`endif

    // freeze is combinational so the multiply is held in EX from the very cycle it is seen.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        freeze  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    freeze  = 1'b1;
                    count_d = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                step    = 1'b1;
                freeze  = 1'b1;
                count_d = count_q + MULT_CNT_W'(1);
                if (last_iter) begin
                    finish  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign busy = (state_q != IDLE);

    mult_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk              (clk),
        .reset            (reset),
        .load             (load),
        .step             (step),
        .finish           (finish),
        .signed_op        (signed_op),
        .op_a             (op_a),
        .op_b             (op_b),
`ifdef MULT_EARLY_EXIT_EN
        .mplier_next_zero (mplier_next_zero),
`endif
        .product_lo       (product_lo),
        .product_hi       (product_hi)
    );

endmodule

// File: tb/tb_mult_seq.sv
// Directed bench for mult_seq: hand-computed products, freeze/done timing, reset abort, back-to-back ops.
module tb_mult_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        freeze;
    logic        busy;
    logic        done;
    logic [31:0] product_lo;
    logic [31:0] product_hi;

    int total = 0;
    int bad   = 0;

    mult_seq #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_op  (signed_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .freeze     (freeze),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle (counted from the start cycle) in which done should be seen.
    function automatic int exp_done_cycle(input logic sop, input logic [31:0] b);
`ifdef MULT_EARLY_EXIT_EN
        logic [31:0] mag;
        int          n;
        mag = (sop && b[31]) ? -b : b;
        n   = 0;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) n = i + 1;
        end
        if (n < 1) n = 1;
        return n + 1;
`else
        if (sop === 1'bx || b === 'x) return -1;
        return 33;
`endif
    endfunction

    // Entered just after a posedge or at a negedge while the DUT is in IDLE; returns in IDLE.
    task automatic run_mult(input string tag, input logic sop, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
        int cyc;
        int frz;
        int exp_cyc;
        exp_cyc   = exp_done_cycle(sop, b);
        signed_op = sop;
        op_a      = a;
        op_b      = b;
        start     = 1'b1;
        #1;
        check({tag, ".freeze_c0"}, 64'(freeze), 64'd1);
        frz = freeze ? 1 : 0;
        @(posedge clk);
        #1;
        start     = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        signed_op = ~sop;
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (done) break;
            if (freeze) frz++;
            @(posedge clk);
            #1;
        end
        check({tag, ".done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, ".freeze_len"}, 64'(frz), 64'(exp_cyc));
        check({tag, ".freeze_at_done"}, 64'(freeze), 64'd0);
        check({tag, ".busy_at_done"}, 64'(busy), 64'd1);
        check({tag, ".product"}, {product_hi, product_lo}, {exp_hi, exp_lo});
        @(posedge clk);
        #1;
        @(negedge clk);
        check({tag, ".done_pulse"}, 64'(done), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
        check({tag, ".hold"}, {product_hi, product_lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst.freeze", 64'(freeze), 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.product", {product_hi, product_lo}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        run_mult("multu_7x6",       1'b0, 32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A);
        run_mult("mult_m3x5",       1'b1, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_mult("multu_ffxff",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_mult("mult_ffxff",      1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_mult("mult_min_x_min",  1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mult("mult_7xm2",       1'b1, 32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
        run_mult("multu_min_x2",    1'b0, 32'h8000_0000, 32'd2,       32'h0000_0001, 32'h0000_0000);
        run_mult("multu_5x3",       1'b0, 32'd5,        32'd3,        32'h0000_0000, 32'h0000_000F);
        run_mult("multu_x0",        1'b0, 32'h1234_5678, 32'd0,       32'h0000_0000, 32'h0000_0000);

        // Back-to-back: the second start is presented in the IDLE cycle right after DONE.
        run_mult("b2b_a",           1'b0, 32'd9,        32'd11,       32'h0000_0000, 32'd99);
        run_mult("b2b_b",           1'b1, 32'hFFFF_FFF8, 32'd100,     32'hFFFF_FFFF, 32'hFFFF_FCE0);

        // Reset aborts an operation mid-CALC with no done pulse.
        signed_op = 1'b0;
        op_a      = 32'd123;
        op_b      = 32'hFFFF_0000;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        @(negedge clk);
        check("abort.busy_before_edge", 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.freeze", 64'(freeze), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.product", {product_hi, product_lo}, 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("abort.no_done", 64'(done), 64'd0);
        end
        reset = 1'b1;
        run_mult("after_abort",     1'b0, 32'd1000,     32'd1000,     32'h0000_0000, 32'd1000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
